// File: rtl/decoder38_rr_arbiter.sv
// Round-robin arbiter for eight requesters; the winner index drives a registered 3-8 decode (active-low gnt_n).
// Latency: request sampled in IDLE/GAP -> grant visible 1 cycle later; release -> one dead GAP cycle.
// Backpressure: a grant is held until done, request withdrawal, or (with ARB_TIMEOUT_EN) TIMEOUT_CYC cycles.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   req[7:0]          - per-requester request, held high until the requester is finished
//   done              - current holder finished (only looked at while granting)
//   gnt_idx[2:0]      - registered winner index, doubles as decoder select A2..A0
//   gnt_vld           - grant active
//   gnt_n[7:0]        - registered active-low one-hot decode, 8'hFF when no grant
//   busy              - in GRANT or GAP
//   timeout           - one-cycle pulse in the GAP that follows a forced release
// Optional feature macro: ARB_TIMEOUT_EN (grant length limit of TIMEOUT_CYC cycles).
module decoder38_rr_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic [7:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] idx_nxt;
    logic       vld_nxt;
    logic       to_nxt;
    logic [7:0] gnt_n_nxt;

    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_found;
    logic       release_norm;
    logic       release_any;
    logic       to_hit;

    // Search ptr+1 .. ptr+8 (the last step wraps back onto ptr itself).
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_norm = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] to_cnt;

    // Counter sits at zero outside GRANT, so it is already clear on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= 8'd0;
        end else if (state != ST_GRANT) begin
            to_cnt <= 8'd0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign to_hit = (state == ST_GRANT) && (to_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign to_hit             = 1'b0;
`endif

    assign release_any = release_norm | to_hit;

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 3'd7;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
            gnt_n   <= 8'hFF;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
            gnt_n   <= gnt_n_nxt;
            timeout <= to_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GRANT: begin
                if (release_any) begin
                    state_nxt = ST_GAP;
                end
            end
            default: begin
                state_nxt = win_found ? ST_GRANT : ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        idx_nxt = gnt_idx;
        ptr_nxt = ptr;
        vld_nxt = 1'b0;
        to_nxt  = 1'b0;
        case (state)
            ST_GRANT: begin
                if (release_any) begin
                    ptr_nxt = gnt_idx;
                    // A coincident done makes it a normal release.
                    to_nxt  = to_hit & ~release_norm;
                end else begin
                    vld_nxt = 1'b1;
                end
            end
            default: begin
                if (win_found) begin
                    idx_nxt = win_idx;
                    vld_nxt = 1'b1;
                end
            end
        endcase
        gnt_n_nxt = vld_nxt ? ~(8'b1 << idx_nxt) : 8'hFF;
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_decoder38_rr_arbiter.sv
module tb_decoder38_rr_arbiter;

    localparam int TCYC = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt_n;
    logic       busy;
    logic       timeout;

    decoder38_rr_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = granting, 2 = dead gap.
    int m_phase;
    int m_ptr;
    int m_idx;
    int m_len;
    bit m_to;

    function automatic int pick(input int p, input logic [7:0] r);
        for (int i = 1; i <= 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 7;
        m_idx   = 0;
        m_len   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        bit rel_norm;
        bit rel_to;
        int k;
        if (m_phase == 1) begin
            rel_norm = d || !r[m_idx];
            rel_to   = TO_EN && (m_len >= TCYC);
            if (rel_norm || rel_to) begin
                m_ptr   = m_idx;
                m_phase = 2;
                m_to    = !rel_norm;
            end else begin
                m_len++;
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            k = pick(m_ptr, r);
            if (k >= 0) begin
                m_idx   = k;
                m_phase = 1;
                m_len   = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_n;
        exp_n = (m_phase == 1) ? ~(8'h01 << m_idx) : 8'hFF;
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_vld", 32'(gnt_vld), 32'(m_phase == 1));
        chk("gnt_n",   32'(gnt_n),   32'(exp_n));
        chk("busy",    32'(busy),    32'(m_phase != 0));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // One clock: drive, let the edge happen, advance model, check just after the edge.
    task automatic cyc(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] rreq;

    initial begin
        model_reset();

        // Reset state
        do_reset();
        chk("rst_vld",  32'(gnt_vld), 32'd0);
        chk("rst_gntn", 32'(gnt_n),   32'hFF);
        chk("rst_busy", 32'(busy),    32'd0);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b1);

        // Single requester: grant, gap, re-grant
        cyc(8'h08, 1'b0);
        chk("single_idx",  32'(gnt_idx), 32'd3);
        chk("single_gntn", 32'(gnt_n),   32'hF7);
        cyc(8'h08, 1'b1);
        chk("single_gap",  32'(gnt_vld), 32'd0);
        cyc(8'h08, 1'b0);
        chk("single_regrant", 32'(gnt_idx), 32'd3);
        chk("single_regrant_vld", 32'(gnt_vld), 32'd1);

        // Async reset mid-grant: outputs drop before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_gntn", 32'(gnt_n),   32'hFF);
        chk("async_vld",  32'(gnt_vld), 32'd0);
        chk("async_busy", 32'(busy),    32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Round-robin over all eight
        cyc(8'hFF, 1'b0);
        chk("rr_first", 32'(gnt_idx), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(8'hFF, 1'b1);
            chk("rr_gap", 32'(gnt_vld), 32'd0);
            cyc(8'hFF, 1'b0);
            chk("rr_order", 32'(gnt_idx), 32'(k % 8));
        end

        // Wrap and skip from ptr=6
        do_reset();
        cyc(8'h40, 1'b0);
        cyc(8'h40, 1'b1);
        cyc(8'h41, 1'b0);
        chk("wrap_idx", 32'(gnt_idx), 32'd0);
        cyc(8'h41, 1'b1);
        cyc(8'h41, 1'b0);
        chk("skip_idx", 32'(gnt_idx), 32'd6);

        // Withdraw
        do_reset();
        cyc(8'h20, 1'b0);
        chk("wd_idx", 32'(gnt_idx), 32'd5);
        cyc(8'h04, 1'b0);
        chk("wd_gap", 32'(gnt_vld), 32'd0);
        cyc(8'h04, 1'b0);
        chk("wd_next", 32'(gnt_idx), 32'd2);

        // Grant-length limit (model decides whether it applies)
        do_reset();
        for (int k = 0; k < 6; k++) cyc(8'h03, 1'b0);
        if (TO_EN) chk("to_next_idx", 32'(gnt_idx), 32'd1);
        for (int k = 0; k < 3; k++) cyc(8'h03, 1'b0);
        cyc(8'h03, 1'b1);
        chk("to_done_same_edge", 32'(timeout), 32'd0);

        // Randomized traffic
        do_reset();
        rreq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rreq[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) rreq = 8'($urandom);
            cyc(rreq, ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
